// File: rtl/mode_switch_ctrl_if.sv
// Bundle between the play-mode engines and the shared buzzer/LED/7-seg outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the outputs are level signals and are held until they change.
interface mode_switch_ctrl_if #(
  parameter int NUM_SRC = 3,
  parameter int NOTE_W  = 4,
  parameter int LED_W   = 7,
  parameter int NUM_W   = 4
);
  localparam int SRC_W = $clog2(NUM_SRC);

  // engine side: mode select, button and packed engine outputs
  logic [NUM_SRC-1:0]        mode;
  logic                      start;
  logic [NUM_SRC*NOTE_W-1:0] src_note;
  logic [NUM_SRC*2-1:0]      src_octave;
  logic [NUM_SRC*LED_W-1:0]  src_led;
  logic [NUM_SRC*NUM_W-1:0]  src_num;

  // driver side: the selected engine plus status flags
  logic [NOTE_W-1:0]         note_out;
  logic [1:0]                octave_out;
  logic [LED_W-1:0]          led_out;
  logic [NUM_W-1:0]          num_out;
  logic                      play_state;
  logic [SRC_W-1:0]          active_src;
  logic                      switching;
  logic                      mode_err;

  modport master (
    output mode, start, src_note, src_octave, src_led, src_num,
    input  note_out, octave_out, led_out, num_out,
           play_state, active_src, switching, mode_err
  );

  modport slave (
    input  mode, start, src_note, src_octave, src_led, src_num,
    output note_out, octave_out, led_out, num_out,
           play_state, active_src, switching, mode_err
  );
endinterface

// File: rtl/mode_switch_ctrl.sv
// Picks one play-mode engine by one-hot mode and registers its note/octave/LED/number outputs.
// Latency: 1 cycle from src_* in ACTIVE; a mode change mutes the outputs for MUTE_CYCLES+1 cycles.
// Backpressure: none; the outputs are level signals, and invalid modes force all data to zero.
module mode_switch_ctrl #(
  parameter int NUM_SRC     = 3,
  parameter int NOTE_W      = 4,
  parameter int LED_W       = 7,
  parameter int NUM_W       = 4,
  parameter int MUTE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  mode_switch_ctrl_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MUTE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_MUTE    = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   mute_cnt, mute_cnt_nxt;
  logic [NUM_SRC-1:0] mode_q;
  logic               start_q;

  logic [NUM_SRC-1:0] mode_m1;
  logic               valid, changed, rise;
  logic [SRC_W-1:0]   idx;

  logic [NOTE_W-1:0]  note_nxt;
  logic [1:0]         octave_nxt;
  logic [LED_W-1:0]   led_nxt;
  logic [NUM_W-1:0]   num_nxt;
  logic               play_nxt, switching_nxt, mode_err_nxt;
  logic [SRC_W-1:0]   active_nxt;

  // a one-hot code is non-zero with no second bit set
  assign mode_m1 = bus.mode - NUM_SRC'(1);
  assign valid   = (bus.mode != '0) && ((bus.mode & mode_m1) == '0);
  assign changed = (bus.mode != mode_q);
  assign rise    = bus.start & ~start_q;

  // convert the one-hot mode to an engine index (only meaningful when valid)
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.mode[i]) idx = SRC_W'(i);
    end
  end

  // state register and mute counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INVALID;
      mute_cnt <= '0;
    end else begin
      state    <= state_nxt;
      mute_cnt <= mute_cnt_nxt;
    end
  end

  // next state: invalid beats changed beats normal; a change reloads (never extends) the mute count
  always_comb begin
    state_nxt    = state;
    mute_cnt_nxt = mute_cnt;
    if (!valid) begin
      state_nxt = ST_INVALID;
    end else if (changed) begin
      state_nxt    = ST_MUTE;
      mute_cnt_nxt = CNT_W'(MUTE_CYCLES - 1);
    end else begin
      case (state)
        ST_MUTE: begin
          if (mute_cnt == '0) state_nxt = ST_ACTIVE;
          else                mute_cnt_nxt = mute_cnt - CNT_W'(1);
        end
        default: state_nxt = state;
      endcase
    end
  end

  // next output values; data is forwarded only in steady ACTIVE, and switching spans the whole muted window
  always_comb begin
    note_nxt      = '0;
    octave_nxt    = '0;
    led_nxt       = '0;
    num_nxt       = '0;
    play_nxt      = bus.play_state;
    active_nxt    = bus.active_src;
    switching_nxt = 1'b0;
    mode_err_nxt  = 1'b0;
    if (!valid) begin
      mode_err_nxt = 1'b1;
      play_nxt     = 1'b0;
    end else if (changed) begin
      active_nxt    = idx;
      play_nxt      = 1'b0;
      switching_nxt = 1'b1;
    end else begin
      case (state)
        ST_MUTE: switching_nxt = 1'b1;
        ST_ACTIVE: begin
          note_nxt   = bus.src_note[bus.active_src*NOTE_W +: NOTE_W];
          octave_nxt = bus.src_octave[bus.active_src*2 +: 2];
          led_nxt    = bus.src_led[bus.active_src*LED_W +: LED_W];
          num_nxt    = bus.src_num[bus.active_src*NUM_W +: NUM_W];
          play_nxt   = bus.play_state ^ rise;
        end
        default: begin
          mode_err_nxt = 1'b1;
          play_nxt     = 1'b0;
        end
      endcase
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.note_out   <= '0;
      bus.octave_out <= '0;
      bus.led_out    <= '0;
      bus.num_out    <= '0;
      bus.play_state <= 1'b0;
      bus.active_src <= '0;
      bus.switching  <= 1'b0;
      bus.mode_err   <= 1'b0;
    end else begin
      bus.note_out   <= note_nxt;
      bus.octave_out <= octave_nxt;
      bus.led_out    <= led_nxt;
      bus.num_out    <= num_nxt;
      bus.play_state <= play_nxt;
      bus.active_src <= active_nxt;
      bus.switching  <= switching_nxt;
      bus.mode_err   <= mode_err_nxt;
    end
  end

  // input history for change and rising-edge detection; cleared mode makes the first valid mode a change
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= '0;
      start_q <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      start_q <= bus.start;
    end
  end
endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Directed bench for mode_switch_ctrl with NUM_SRC=3, MUTE_CYCLES=4.
// Latency: expected values are queued when inputs are driven and compared one edge later.
// Backpressure: none; every step is a single fixed clock cycle.
module tb_mode_switch_ctrl;
  typedef struct {
    logic [3:0] note;
    logic [1:0] oct;
    logic [6:0] led;
    logic [3:0] num;
    logic       play;
    logic [1:0] act;
    logic       sw;
    logic       err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   step;
  exp_t sb_q[$];

  logic [3:0] e_note[3];
  logic [1:0] e_oct[3];
  logic [6:0] e_led[3];
  logic [3:0] e_num[3];

  mode_switch_ctrl_if #(.NUM_SRC(3), .NOTE_W(4), .LED_W(7), .NUM_W(4)) bus ();

  mode_switch_ctrl #(
    .NUM_SRC(3), .NOTE_W(4), .LED_W(7), .NUM_W(4), .MUTE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pack_src();
    for (int i = 0; i < 3; i++) begin
      bus.src_note[i*4 +: 4]   = e_note[i];
      bus.src_octave[i*2 +: 2] = e_oct[i];
      bus.src_led[i*7 +: 7]    = e_led[i];
      bus.src_num[i*4 +: 4]    = e_num[i];
    end
  endtask

  // muted / invalid expectation: all data zero
  function automatic exp_t z(input logic play, input logic [1:0] act, input logic sw, input logic err);
    exp_t e;
    e.note = '0; e.oct = '0; e.led = '0; e.num = '0;
    e.play = play; e.act = act; e.sw = sw; e.err = err;
    return e;
  endfunction

  // steady expectation: engine i's current data
  function automatic exp_t d(input int i, input logic play);
    exp_t e;
    e.note = e_note[i]; e.oct = e_oct[i]; e.led = e_led[i]; e.num = e_num[i];
    e.play = play; e.act = 2'(i); e.sw = 1'b0; e.err = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s step %0d observed=%0h expected=%0h", tag, step, obs, exp_v);
    end
  endtask

  // queue the expectation, advance one edge, then compare the DUT against the queue head
  task automatic cyc(input exp_t e);
    exp_t g;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    step++;
    g = sb_q.pop_front();
    chk("note_out",   32'(bus.note_out),   32'(g.note));
    chk("octave_out", 32'(bus.octave_out), 32'(g.oct));
    chk("led_out",    32'(bus.led_out),    32'(g.led));
    chk("num_out",    32'(bus.num_out),    32'(g.num));
    chk("play_state", 32'(bus.play_state), 32'(g.play));
    chk("active_src", 32'(bus.active_src), 32'(g.act));
    chk("switching",  32'(bus.switching),  32'(g.sw));
    chk("mode_err",   32'(bus.mode_err),   32'(g.err));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    step  = 0;
    e_note[0] = 4'd3; e_oct[0] = 2'd1; e_led[0] = 7'h11; e_num[0] = 4'd2;
    e_note[1] = 4'd5; e_oct[1] = 2'd2; e_led[1] = 7'h22; e_num[1] = 4'd4;
    e_note[2] = 4'd7; e_oct[2] = 2'd3; e_led[2] = 7'h44; e_num[2] = 4'd6;
    pack_src();
    reset     = 1'b1;
    bus.mode  = 3'b000;
    bus.start = 1'b0;

    // reset state
    repeat (2) cyc(z(1'b0, 2'd0, 1'b0, 1'b0));

    // release into engine 1: five muted cycles, data on the sixth edge
    reset    = 1'b0;
    bus.mode = 3'b010;
    repeat (5) cyc(z(1'b0, 2'd1, 1'b1, 1'b0));
    cyc(d(1, 1'b0));
    cyc(d(1, 1'b0));

    // one-cycle data latency
    e_note[1] = 4'd9; pack_src();
    cyc(d(1, 1'b0));
    e_note[1] = 4'd5; pack_src();
    cyc(d(1, 1'b0));

    // invalid codes: two bits set, then none
    bus.mode = 3'b011;
    cyc(z(1'b0, 2'd1, 1'b0, 1'b1));
    bus.mode = 3'b000;
    cyc(z(1'b0, 2'd1, 1'b0, 1'b1));

    // recover into engine 0
    bus.mode = 3'b001;
    repeat (5) cyc(z(1'b0, 2'd0, 1'b1, 1'b0));
    cyc(d(0, 1'b0));

    // held start toggles once; second press toggles back; third press leaves play on
    bus.start = 1'b1;
    repeat (10) cyc(d(0, 1'b1));
    bus.start = 1'b0; cyc(d(0, 1'b1));
    bus.start = 1'b1; cyc(d(0, 1'b0));
    bus.start = 1'b0; cyc(d(0, 1'b0));
    bus.start = 1'b1; cyc(d(0, 1'b1));
    bus.start = 1'b0; cyc(d(0, 1'b1));

    // mode change coinciding with a start rise: the change wins
    bus.mode  = 3'b100;
    bus.start = 1'b1;
    cyc(z(1'b0, 2'd2, 1'b1, 1'b0));
    bus.start = 1'b0;
    cyc(z(1'b0, 2'd2, 1'b1, 1'b0));

    // second change mid-mute reloads the counter; start pulse inside mute is ignored
    bus.mode  = 3'b010;
    bus.start = 1'b1;
    cyc(z(1'b0, 2'd1, 1'b1, 1'b0));
    bus.start = 1'b0;
    repeat (4) cyc(z(1'b0, 2'd1, 1'b1, 1'b0));
    cyc(d(1, 1'b0));
    cyc(d(1, 1'b0));

    // reset in the middle of a mute window, then release into a fresh mute
    bus.mode = 3'b001;
    repeat (2) cyc(z(1'b0, 2'd0, 1'b1, 1'b0));
    reset = 1'b1;
    cyc(z(1'b0, 2'd0, 1'b0, 1'b0));
    reset = 1'b0;
    cyc(z(1'b0, 2'd0, 1'b1, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mode_switch_ctrl.md
Name: mode_switch_ctrl

Overview:
- Parametrised successor to the piano top-level mode selector.
- Selects one of NUM_SRC play-mode engines (free, auto, learn, record-playback, ...) using a one-hot mode bus, and registers that engine's note/octave/LED/song-number onto the shared outputs.
- Adds behaviour the previous selector lacked: glitch-free mode switching with a timed mute window, rejection of invalid mode codes, and a start button that toggles play state on its rising edge only.
- Sits between the mode engines and the buzzer/LED/7-seg drivers.

Parameters:
- NUM_SRC, 3, number of mode engines; one-hot mode width; range 2..8.
- NOTE_W, 4, note code width per engine.
- LED_W, 7, LED pattern width per engine.
- NUM_W, 4, song-number width per engine.
- MUTE_CYCLES, 4, clk cycles outputs are held silent after any mode change; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  NUM_SRC  one-hot mode select; bit i selects engine i.
- start  in  1  start/pause button level, already synchronised.
- src_note  in  NUM_SRC*NOTE_W  engine notes; engine i occupies bits [i*NOTE_W +: NOTE_W].
- src_octave  in  NUM_SRC*2  engine octaves, packed the same way.
- src_led  in  NUM_SRC*LED_W  engine LED patterns, packed the same way.
- src_num  in  NUM_SRC*NUM_W  engine song numbers, packed the same way.
- note_out  out  NOTE_W  registered selected note; 0 means rest.
- octave_out  out  2  registered selected octave.
- led_out  out  LED_W  registered selected LED pattern.
- num_out  out  NUM_W  registered selected song number.
- play_state  out  1  play/pause flag returned to the engines.
- active_src  out  clog2(NUM_SRC)  index of the currently driving engine.
- switching  out  1  high while in the MUTE state.
- mode_err  out  1  high while in the INVALID state.

Behaviour:
- Reset (sync, high) sets every output and internal register to 0 and the state to INVALID.
  - The mode_q register is cleared to 0, so the first valid mode after reset counts as a change.
- Mode checking:
  - valid = mode has exactly one bit set.
  - idx = position of that bit.
  - changed = (mode != mode_q).
  - mode_q <= mode every cycle.
- States: INVALID, MUTE, ACTIVE. Priority each cycle is reset, then invalid, then changed, then normal.
  - Any state, mode not valid: go to INVALID; mode_err=1; all data outputs 0; play_state <= 0.
  - Valid and changed (from any state): go to MUTE; load mute_cnt = MUTE_CYCLES-1; active_src <= idx; play_state <= 0; data outputs 0.
  - MUTE, valid and unchanged:
    - If mute_cnt == 0, go to ACTIVE.
    - Otherwise decrement mute_cnt.
    - Outputs stay 0 throughout.
  - A mode change during MUTE reloads the counter; it does not extend it additively.
  - ACTIVE, valid and unchanged: each cycle register engine active_src onto note_out, octave_out, led_out and num_out. Latency is 1 cycle from the src_* inputs.
- Mute timing: from the first cycle the new mode is sampled, outputs are 0 for exactly MUTE_CYCLES+1 cycles. The first non-zero output appears on the MUTE_CYCLES+2 edge.
- Start button:
  - start_q <= start each cycle; rise = start & ~start_q.
  - In ACTIVE, rise toggles play_state.
  - In MUTE or INVALID, rise is ignored and start_q still updates.
  - A held start produces exactly one toggle.
  - If a rise coincides with a mode change, the change wins and play_state becomes 0.
- Output gating: none beyond the rules above. Engines observe play_state themselves; the selector forwards their outputs regardless of play_state.
- Width rules: all selection uses indexed part-selects; no arithmetic on data. mute_cnt is clog2(MUTE_CYCLES+1) bits wide and never wraps.

Test Plan (NUM_SRC=3, MUTE_CYCLES=4):
- Reset release, then mode=3'b010 with src_note for engine 1 = 4'd5:
  - note_out stays 0 and switching=1 for 5 cycles.
  - note_out=5 and active_src=1 on the 6th edge.
  - switching=0 from then on.
- In ACTIVE engine 1, change engine-1 src_note 5→9 on one cycle: note_out shows 9 exactly one edge later.
- mode=3'b011, then 3'b000:
  - mode_err=1 and all outputs 0 within 1 edge.
  - Returning to 3'b001 restarts MUTE, with active_src=0 after the 5 muted cycles.
- In ACTIVE, start held high for 10 cycles: play_state toggles 0→1 once. Release, then a second press gives 1→0.
- Mode 3'b001→3'b100 while play_state=1, with a start rise in the same cycle: play_state=0 and switching=1. Start pulses during MUTE leave play_state at 0.
- During MUTE after 2 cycles, mode changes again to 3'b010: the mute counter reloads, 5 more muted cycles follow, then engine 1 drives the outputs. Assert reset mid-MUTE: all outputs 0 and the state is INVALID on the next edge.
